// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: owns the single frame-buffer RAM port. The display fetch
// path always wins the port. Paint requests are read-modify-write nibble
// merges that slip into the cycles the display leaves free.
// Optional feature macro: FB_CLEAR_EN (full-screen fill state machine).
module fb_access_arbiter #(
    parameter int H_ACTIVE       = 640,
    parameter int DRAW_TOP       = 80,
    parameter int DRAW_BOTTOM    = 480,
    parameter int WORDS_PER_LINE = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic [15:0] disp_word,
    output logic        disp_valid,
    input  logic        pnt_req,
    input  logic [10:0] pnt_x,
    input  logic [10:0] pnt_y,
    input  logic [3:0]  pnt_color,
    output logic        pnt_ack,
    output logic        pnt_err,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    input  logic        clear_req,
    input  logic [3:0]  clear_color,
    output logic        clear_done
);

    localparam int LAST_ADDR = WORDS_PER_LINE * (DRAW_BOTTOM - DRAW_TOP) - 1;

`ifdef FB_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ACK, S_ERR, S_CLEAR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ACK, S_ERR} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  nib_q, nib_d;
    logic [3:0]  color_q, color_d;
    logic [15:0] merge_q, merge_d;
    logic        disp_flag_q;
    logic [15:0] disp_word_q;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ccolor_q, ccolor_d;

    logic [15:0] row16;
    logic [15:0] paint_addr;
    logic        out_of_range;

    // Replace nibble n of a word with the paint colour.
    function automatic logic [15:0] merge_nibble(input logic [15:0] w, input logic [1:0] n,
                                                 input logic [3:0] c);
        logic [15:0] r;
        r = w;
        r[{n, 2'b00} +: 4] = c;
        return r;
    endfunction

    // Word address and range check for the requested pixel; row*160 as shift-add.
    always_comb begin
        row16        = {5'b0, pnt_y - 11'(DRAW_TOP)};
        paint_addr   = (row16 << 7) + (row16 << 5) + {7'b0, pnt_x[10:2]};
        out_of_range = (pnt_y < 11'(DRAW_TOP)) || (pnt_y >= 11'(DRAW_BOTTOM)) ||
                       (pnt_x >= 11'(H_ACTIVE));
    end

    // Next-state logic and RAM port multiplexing; display always owns the port when requesting.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        nib_d     = nib_q;
        color_d   = color_q;
        merge_d   = merge_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        ccolor_d  = ccolor_q;
        mem_addr  = 16'h0000;
        mem_we    = 1'b0;
        mem_wdata = 16'h0000;
        if (disp_req) mem_addr = disp_addr;
        case (state_q)
            S_IDLE: begin
`ifdef FB_CLEAR_EN
                if (clear_req) begin
                    cnt_d    = 16'h0000;
                    ccolor_d = clear_color;
                    state_d  = S_CLEAR;
                end else
`endif
                // ack_q high means the requester has not yet dropped the old request
                if (pnt_req && !ack_q) begin
                    addr_d  = paint_addr;
                    nib_d   = pnt_x[1:0];
                    color_d = pnt_color;
                    state_d = out_of_range ? S_ERR : S_RD;
                end
            end
            S_RD: begin
                if (!disp_req) begin
                    mem_addr = addr_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // rdata here is the paint read; a display grant now returns next cycle
                merge_d = merge_nibble(mem_rdata, nib_q, color_q);
                state_d = S_WR;
            end
            S_WR: begin
                if (!disp_req) begin
                    mem_addr  = addr_q;
                    mem_we    = 1'b1;
                    mem_wdata = merge_q;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
`ifdef FB_CLEAR_EN
            S_CLEAR: begin
                if (!disp_req) begin
                    mem_addr  = cnt_q;
                    mem_we    = 1'b1;
                    mem_wdata = {4{ccolor_q}};
                    if (cnt_q == 16'(LAST_ADDR)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            nib_q       <= 2'b00;
            color_q     <= 4'h0;
            merge_q     <= 16'h0000;
            disp_flag_q <= 1'b0;
            disp_word_q <= 16'h0000;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 16'h0000;
            ccolor_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            nib_q       <= nib_d;
            color_q     <= color_d;
            merge_q     <= merge_d;
            disp_flag_q <= disp_req;
            if (disp_flag_q) disp_word_q <= mem_rdata;
            ack_q       <= ack_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            ccolor_q    <= ccolor_d;
        end
    end

    // Display word is live during the valid pulse and held afterwards.
    always_comb begin
        disp_valid = disp_flag_q;
        disp_word  = disp_flag_q ? mem_rdata : disp_word_q;
        pnt_ack    = ack_q;
        pnt_err    = err_q;
`ifdef FB_CLEAR_EN
        busy       = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR) ||
                     (state_q == S_CLEAR);
        clear_done = done_q;
`else
        busy       = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
        clear_done = 1'b0;
`endif
    end

`ifndef FB_CLEAR_EN
    logic        unused_clear;
    logic [15:0] unused_last;
    assign unused_clear = ^{clear_req, clear_color, done_q, cnt_q, ccolor_q};
    assign unused_last  = 16'(LAST_ADDR);
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural 1-cycle RAM.
module tb_fb_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic [15:0] disp_word;
    logic        disp_valid;
    logic        pnt_req;
    logic [10:0] pnt_x;
    logic [10:0] pnt_y;
    logic [3:0]  pnt_color;
    logic        pnt_ack;
    logic        pnt_err;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        clear_req;
    logic [3:0]  clear_color;
    logic        clear_done;

    logic [15:0] ram [0:65535];
    int errors = 0;
    int checks = 0;

    fb_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_word(disp_word), .disp_valid(disp_valid),
        .pnt_req(pnt_req), .pnt_x(pnt_x), .pnt_y(pnt_y), .pnt_color(pnt_color),
        .pnt_ack(pnt_ack), .pnt_err(pnt_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .clear_req(clear_req), .clear_color(clear_color), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One paint transaction with no display traffic; checks ack, error, latency and the write.
    task automatic do_paint(input string tag, input int x, input int y, input int c,
                            input bit exp_err, input int exp_addr, input int exp_data,
                            input int exp_lat);
        int n_we = 0;
        int lat = 0;
        bit got = 0;
        logic [15:0] wa = 16'h0;
        logic [15:0] wd = 16'h0;
        pnt_x = 11'(x); pnt_y = 11'(y); pnt_color = 4'(c); pnt_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (mem_we) begin n_we++; wa = mem_addr; wd = mem_wdata; end
            if (pnt_ack) got = 1;
        end
        chk({tag, " ack"}, 32'(got), 32'd1);
        chk({tag, " err"}, 32'(pnt_err), 32'(exp_err));
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " writes"}, 32'(n_we), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) begin
            chk({tag, " waddr"}, 32'(wa), 32'(exp_addr));
            chk({tag, " wdata"}, 32'(wd), 32'(exp_data));
        end
        tick();
        pnt_req = 1'b0;
        chk({tag, " ack one cycle"}, 32'(pnt_ack), 32'd0);
        tick();
        chk({tag, " idle"}, 32'(busy), 32'd0);
        if (!exp_err) chk({tag, " ram"}, 32'(ram[exp_addr]), 32'(exp_data));
    endtask

    initial begin
        int acks;
        rst_n = 1'b0; disp_req = 1'b0; disp_addr = 16'h0; pnt_req = 1'b0;
        pnt_x = 11'd0; pnt_y = 11'd0; pnt_color = 4'h0; clear_req = 1'b0; clear_color = 4'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        tick(); tick();
        chk("rst disp_valid", 32'(disp_valid), 32'd0);
        chk("rst disp_word", 32'(disp_word), 32'd0);
        chk("rst pnt_ack", 32'(pnt_ack), 32'd0);
        chk("rst pnt_err", 32'(pnt_err), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst clear_done", 32'(clear_done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic merges at several nibble positions and the far corner.
        ram[1] = 16'h1234;
        do_paint("p1", 5, 80, 'hA, 0, 1, 'h12A4, 5);
        ram[63999] = 16'h0000;
        do_paint("p2", 639, 479, 'h7, 0, 63999, 'h7000, 5);
        ram[160] = 16'h0000;
        do_paint("p3", 2, 81, 'hF, 0, 160, 'h0F00, 5);
        ram[35200] = 16'hFFFF;
        do_paint("p4", 3, 300, 'h5, 0, 35200, 'h5FFF, 5);

        // Out-of-range requests.
        do_paint("e_y79", 10, 79, 'h1, 1, 0, 0, 2);
        do_paint("e_x640", 640, 100, 'h1, 1, 0, 0, 2);
        do_paint("e_y480", 0, 480, 'h1, 1, 0, 0, 2);

        // Display contention in RD and WR.
        for (int i = 0; i < 10; i++) ram[500 + i] = 16'hB000 + 16'(i);
        pnt_x = 11'd4; pnt_y = 11'd80; pnt_color = 4'hC; pnt_req = 1'b1;
        tick();
        chk("c rd busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            disp_req = 1'b1; disp_addr = 16'(500 + i);
            #1;
            chk("c rd mem_addr", 32'(mem_addr), 32'(500 + i));
            chk("c rd mem_we", 32'(mem_we), 32'd0);
            tick();
            chk("c disp_valid", 32'(disp_valid), 32'd1);
            chk("c disp_word", 32'(disp_word), 32'hB000 + 32'(i));
        end
        disp_req = 1'b0;
        #1;
        chk("c paint read addr", 32'(mem_addr), 32'd1);
        tick();
        chk("c valid drops", 32'(disp_valid), 32'd0);
        disp_req = 1'b1; disp_addr = 16'd505;
        tick();
        chk("c wait grant valid", 32'(disp_valid), 32'd1);
        chk("c wait grant word", 32'(disp_word), 32'hB005);
        for (int j = 0; j < 3; j++) begin
            chk("c wr stalled we", 32'(mem_we), 32'd0);
            chk("c wr disp addr", 32'(mem_addr), 32'd505);
            tick();
        end
        disp_req = 1'b0;
        #1;
        chk("c wr we", 32'(mem_we), 32'd1);
        chk("c wr addr", 32'(mem_addr), 32'd1);
        chk("c wr data", 32'(mem_wdata), 32'h12AC);
        chk("c held word", 32'(disp_word), 32'hB005);
        tick(); tick();
        chk("c ack", 32'(pnt_ack), 32'd1);
        chk("c err", 32'(pnt_err), 32'd0);
        tick();
        pnt_req = 1'b0;
        tick();
        chk("c ram", 32'(ram[1]), 32'h12AC);

        // Reset in the middle of the write.
        ram[2] = 16'h5555;
        pnt_x = 11'd8; pnt_y = 11'd80; pnt_color = 4'h1; pnt_req = 1'b1;
        tick(); tick(); tick();
        chk("r in wr", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r we drops", 32'(mem_we), 32'd0);
        tick();
        pnt_req = 1'b0;
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pnt_ack) acks++;
        end
        chk("r no ack", 32'(acks), 32'd0);
        chk("r ram kept", 32'(ram[2]), 32'h5555);
        chk("r idle", 32'(busy), 32'd0);
        do_paint("r again", 8, 80, 'h1, 0, 2, 'h5551, 5);

`ifdef FB_CLEAR_EN
        begin
            int bad_we = 0;
            int bad_addr = 0;
            int early_ack = 0;
            int done_cnt = 0;
            int bad_ram = 0;
            int nxt = 0;
            int cyc = 0;
            bit done = 0;
            bit got = 0;
            clear_color = 4'h3; clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            chk("cl busy", 32'(busy), 32'd1);
            pnt_x = 11'd0; pnt_y = 11'd80; pnt_color = 4'h9; pnt_req = 1'b1;
            while (!done && cyc < 80000) begin
                disp_req = (cyc % 16) == 0;
                disp_addr = 16'(cyc);
                #1;
                if (mem_we) begin
                    if (disp_req) bad_we++;
                    if (32'(mem_addr) != nxt) bad_addr++;
                    nxt++;
                end
                if (pnt_ack) early_ack++;
                tick();
                cyc++;
                if (clear_done) begin
                    done = 1;
                    done_cnt++;
                    for (int a = 0; a < 64000; a++) if (ram[a] !== 16'h3333) bad_ram++;
                end
            end
            disp_req = 1'b0;
            chk("cl done seen", 32'(done), 32'd1);
            chk("cl we under disp", 32'(bad_we), 32'd0);
            chk("cl order", 32'(bad_addr), 32'd0);
            chk("cl count", 32'(nxt), 32'd64000);
            chk("cl fill", 32'(bad_ram), 32'd0);
            chk("cl no early ack", 32'(early_ack), 32'd0);
            for (int i = 0; i < 20 && !got; i++) begin
                tick();
                if (clear_done) done_cnt++;
                if (pnt_ack) got = 1;
            end
            chk("cl done pulses", 32'(done_cnt), 32'd1);
            chk("cl paint ack", 32'(got), 32'd1);
            tick();
            pnt_req = 1'b0;
            tick();
            chk("cl paint merge", 32'(ram[0]), 32'h3339);
        end
`else
        clear_color = 4'h3; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("nc busy", 32'(busy), 32'd0);
        chk("nc we", 32'(mem_we), 32'd0);
        tick();
        chk("nc done", 32'(clear_done), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Owns the single port of the 16-bit frame-buffer RAM.
- Shares that port between two requesters:
  - the VGA display fetch path, which supplies word addresses and consumes one 16-bit word holding 4 four-bit pixels;
  - the paint path, which writes one pixel from mouse/draw logic.
- Paint writes are read-modify-write nibble merges; the display always has priority.
- Sits between the pixel generator, the draw controller and the frame-buffer RAM.

Parameters:
H_ACTIVE, 640, drawable width in pixels
DRAW_TOP, 80, first drawable line (palette bar occupies lines above)
DRAW_BOTTOM, 480, first line past drawable area
WORDS_PER_LINE, 160, H_ACTIVE/4 words per line

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
disp_req  in  1  display wants word at disp_addr this cycle
disp_addr  in  16  display word address
disp_word  out  16  last word fetched for display, held until next fetch
disp_valid  out  1  pulses the cycle disp_word updates
pnt_req  in  1  paint request, level, held until pnt_ack
pnt_x  in  11  pixel column, stable while pnt_req
pnt_y  in  11  pixel row, stable while pnt_req
pnt_color  in  4  pixel value (bit2 R, bit1 G, bit0 B, bit3 reserved)
pnt_ack  out  1  one-cycle completion pulse
pnt_err  out  1  valid with pnt_ack; 1 = out of range, nothing written
mem_addr  out  16  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  16  RAM write data
mem_rdata  in  16  RAM read data, 1-cycle synchronous latency
busy  out  1  paint or clear operation in progress
clear_req  in  1  clear pulse (FB_CLEAR_EN only)
clear_color  in  4  fill value (FB_CLEAR_EN only)
clear_done  out  1  one-cycle pulse at clear completion (FB_CLEAR_EN only)

Behaviour:
- Reset: state IDLE; disp_word, disp_valid, pnt_ack, pnt_err, mem_we, mem_addr, mem_wdata, busy and clear_done all 0.
- Reset asserted mid-operation: mem_we drops immediately, no partial write, request discarded, no ack.
- Display grant:
  - disp_req=1 takes the port unconditionally that cycle: mem_addr=disp_addr, mem_we=0.
  - A registered flag marks the next cycle's mem_rdata as display data; in that cycle disp_word<=mem_rdata and disp_valid=1.
  - Display latency is exactly 1 cycle and is never stalled.
- Paint address:
  - Word address = (pnt_y-DRAW_TOP)*160 + pnt_x[10:2], computed as shift-add ((r<<7)+(r<<5)).
  - Range is 0..63999, 16 bits.
  - Nibble n = pnt_x[1:0] selects bits [4n+3:4n].
- Range check at acceptance: pnt_y<DRAW_TOP, pnt_y>=DRAW_BOTTOM, or pnt_x>=H_ACTIVE is out of range -> ERR.
- Paint FSM:
  - IDLE: pnt_req=1 and pnt_ack=0 -> latch x/y/color, busy=1 -> RD, or -> ERR if out of range.
  - RD: disp_req=1 -> stay. Otherwise issue read of the paint address -> WAIT.
  - WAIT: capture mem_rdata (the paint read) into merge reg, replacing nibble n with color -> WR. A display grant this cycle is legal.
  - WR: disp_req=1 -> stay, holding merged data. Otherwise mem_we=1, mem_wdata=merged -> ACK.
  - ACK: pnt_ack=1, pnt_err=0, busy=0 -> IDLE.
  - ERR: pnt_ack=1, pnt_err=1, no RAM access -> IDLE.
- Handshake: the requester drops pnt_req in the cycle after pnt_ack; IDLE ignores pnt_req while pnt_ack=1.
- Paint may stall indefinitely under continuous disp_req; the display source leaves gaps (blanking).
- Only one RAM read issues per cycle, so display and paint read data never overlap.
- Outside FB_CLEAR_EN, clear_req is ignored and clear_done is tied 0.

Optional Feature:
FB_CLEAR_EN
- Defined:
  - clear_req=1 in IDLE -> CLEAR state, busy=1.
  - Writes {4{clear_color}} to addresses 0..63999 ascending, one per cycle in which disp_req=0; the counter holds while the display is granted.
  - pnt_req is not accepted during CLEAR.
  - After address 63999: clear_done pulses 1 cycle -> IDLE.
  - clear_req outside IDLE is ignored.
- Undefined: no CLEAR state or counter; clear_req is ignored and clear_done=0.

Test Plan:
- Reset, then RAM[1]=0x1234; paint x=5 y=80 color=0xA, disp_req=0 -> read addr 1, write 0x12A4 to addr 1; pnt_ack with pnt_err=0 five cycles after acceptance.
- Paint x=639 y=479 color=0x7, RAM[63999]=0x0000 -> write 0x7000 to addr 63999.
- Paint y=79 or x=640 -> pnt_ack=1, pnt_err=1, mem_we never asserted.
- disp_req held high 10 cycles during paint RD/WR -> no paint RAM access or mem_we while disp_req=1; disp_valid each following cycle; disp_word equals RAM[disp_addr]; paint completes after disp_req drops with correct merge.
- rst_n low during WR -> mem_we=0 immediately, RAM unchanged, no pnt_ack; after release, state IDLE.
- FB_CLEAR_EN defined: clear_req with color 0x3, disp_req toggling -> every word 0x3333; clear_done one pulse; pnt_req during clear acked only after clear_done.
